softex_row_padder: RTL and testbench

//  Stream stage between the streamer's input stream and the softmax datapath (replaces the plain in-FIFO).

---
 rtl/softex_row_padder_pkg.sv | 28 ++
 rtl/softex_row_padder_if.sv | 9 +
 rtl/softex_row_padder_lane_mask.sv | 12 +
 rtl/softex_row_padder.sv | 100 ++++++++++
 tb/tb_softex_row_padder.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/softex_row_padder_pkg.sv
// softex_row_padder_pkg: shared types, constants and FP helpers for the row padder
package softex_row_padder_pkg;
  localparam int unsigned CNT_W = 32;
  typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} pad_state_e;
  typedef struct packed {
    logic             start;
    logic [CNT_W-1:0] row_length;
    logic [CNT_W-1:0] n_rows;
  } row_pad_ctrl_t;
  typedef struct packed {
    logic busy;
    logic done;
    logic row_last;
  } row_pad_flags_t;
  function automatic int unsigned fp_exp_bits(fp_format_e f);
    return f == FP64 ? 11 : (f == FP32 || f == FP16ALT) ? 8 : 5;
  endfunction
  function automatic int unsigned fp_man_bits(fp_format_e f);
    return f == FP64 ? 52 : f == FP32 ? 23 : f == FP16 ? 10 : f == FP16ALT ? 7 : 2;
  endfunction
  function automatic int unsigned fp_width(fp_format_e f);
    return 1 + fp_exp_bits(f) + fp_man_bits(f);
  endfunction
  function automatic logic [63:0] fp_neg_inf(fp_format_e f);
    return (64'd1 << (fp_exp_bits(f) + fp_man_bits(f))) | (((64'd1 << fp_exp_bits(f)) - 64'd1) << fp_man_bits(f));
  endfunction
endpackage

// File: rtl/softex_row_padder_if.sv
// softex_row_padder_if: valid/ready element stream with byte strobes
interface softex_row_padder_if #(parameter int unsigned DATA_WIDTH = 224);
  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;
  modport master(output valid, data, strb, input ready);
  modport slave(input valid, data, strb, output ready);
endinterface

// File: rtl/softex_row_padder_lane_mask.sv
// softex_row_padder_lane_mask: marks lanes at or beyond rem as padding; rem==0 pads nothing
module softex_row_padder_lane_mask #(
  parameter int unsigned VECT_WIDTH = 14,
  parameter int unsigned REM_W      = $clog2(VECT_WIDTH + 1)
) (
  input  logic [REM_W-1:0]      rem_i,
  output logic [VECT_WIDTH-1:0] mask_o
);
  for (genvar i = 0; i < VECT_WIDTH; i++) begin : g_lane
    assign mask_o[i] = (rem_i != '0) && (REM_W'(i) >= rem_i);
  end
endmodule

// File: rtl/softex_row_padder.sv
// softex_row_padder: stream stage tracking row position and padding each row's tail lanes with -inf
module softex_row_padder
  import softex_row_padder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 224,
  parameter fp_format_e  FPFORMAT   = FP16ALT,
  parameter int unsigned CNT_WIDTH  = CNT_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  row_pad_ctrl_t       ctrl_i,
  output row_pad_flags_t      flags_o,
  softex_row_padder_if.slave  stream_i,
  softex_row_padder_if.master stream_o
);
  localparam int unsigned WIDTH      = fp_width(FPFORMAT);
  localparam int unsigned VECT_WIDTH = DATA_WIDTH / WIDTH;
  localparam int unsigned REM_W      = $clog2(VECT_WIDTH + 1);
  localparam logic [WIDTH-1:0]     NEG_INF = WIDTH'(fp_neg_inf(FPFORMAT));
  localparam logic [CNT_WIDTH-1:0] VW      = CNT_WIDTH'(VECT_WIDTH);
  // left counts elements still to come in the current row, including the beat at the input
  typedef struct packed {
    logic                    valid;
    logic                    last;
    logic                    fin;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;
    logic [CNT_WIDTH-1:0]    row_len;
    logic [CNT_WIDTH-1:0]    n_rows;
    logic [CNT_WIDTH-1:0]    left;
    logic [CNT_WIDTH-1:0]    row_cnt;
  } regs_t;
  pad_state_e            state_q, state_d;
  regs_t                 r_q, r_d;
  logic [DATA_WIDTH-1:0] data_pad;
  logic [REM_W-1:0]      rem;
  logic [VECT_WIDTH-1:0] mask;
  logic                  in_hs, out_hs, last_beat, job_last;
  assign last_beat       = r_q.left <= VW;
  assign job_last        = last_beat && (r_q.row_cnt + CNT_WIDTH'(1) == r_q.n_rows);
  assign stream_i.ready  = (state_q == RUN) && (r_q.row_cnt != r_q.n_rows) && (!r_q.valid || stream_o.ready);
  assign in_hs           = stream_i.valid && stream_i.ready;
  assign out_hs          = r_q.valid && stream_o.ready;
  assign rem             = (last_beat && r_q.left < VW) ? REM_W'(r_q.left) : '0;
  assign stream_o.valid  = r_q.valid;
  assign stream_o.data   = r_q.data;
  assign stream_o.strb   = r_q.strb;
  assign flags_o         = '{busy: state_q != IDLE, done: state_q == DONE, row_last: r_q.valid && r_q.last};
  softex_row_padder_lane_mask #(.VECT_WIDTH(VECT_WIDTH), .REM_W(REM_W)) i_mask (
    .rem_i  (rem),
    .mask_o (mask)
  );
  // Overwrite padded lanes with -inf; bits above the last full lane pass through untouched
  always_comb begin
    data_pad = stream_i.data;
    for (int l = 0; l < VECT_WIDTH; l++) data_pad[l*WIDTH +: WIDTH] = mask[l] ? NEG_INF : stream_i.data[l*WIDTH +: WIDTH];
  end
  // Next state: FSM transitions, job latching, position counters and the output slot; clear wins
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (ctrl_i.start) begin
          state_d     = (ctrl_i.row_length == '0 || ctrl_i.n_rows == '0) ? DONE : RUN;
          r_d.row_len = CNT_WIDTH'(ctrl_i.row_length);
          r_d.n_rows  = CNT_WIDTH'(ctrl_i.n_rows);
          r_d.left    = CNT_WIDTH'(ctrl_i.row_length);
          r_d.row_cnt = '0;
        end
      end
      RUN:     state_d = (out_hs && r_q.fin) ? DONE : RUN;
      default: state_d = IDLE;
    endcase
    if (in_hs) begin
      r_d.left    = last_beat ? r_q.row_len : r_q.left - VW;
      r_d.row_cnt = last_beat ? r_q.row_cnt + CNT_WIDTH'(1) : r_q.row_cnt;
      r_d.data    = data_pad;
      r_d.strb    = stream_i.strb;
      r_d.last    = last_beat;
      r_d.fin     = job_last;
    end
    r_d.valid = in_hs || (r_q.valid && !stream_o.ready);
    if (clear_i) begin
      state_d = IDLE;
      r_d     = '0;
    end
  end
  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
    end
  end
endmodule

// File: tb/tb_softex_row_padder.sv
// tb_softex_row_padder: randomized scoreboard bench for the row padder (FP16ALT, 14 lanes)
module tb_softex_row_padder;
  import softex_row_padder_pkg::*;
  localparam int DW = 224;
  localparam int VW = 14;
  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    bit              last;
    bit              fin;
  } item_t;
  logic           clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  row_pad_ctrl_t  ctrl = '0;
  row_pad_flags_t flags;
  int             vectors = 0, miscompares = 0, done_cnt = 0, ready_pct = 100;
  item_t          sb[$];
  logic [DW-1:0]  hold_data;
  bit             hold_chk = 0, done_next = 0;
  softex_row_padder_if #(.DATA_WIDTH(DW)) sin();
  softex_row_padder_if #(.DATA_WIDTH(DW)) sout();
  softex_row_padder dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clear_i  (clear),
    .ctrl_i   (ctrl),
    .flags_o  (flags),
    .stream_i (sin),
    .stream_o (sout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    sout.ready = $urandom_range(99) < ready_pct;
  end
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference: element index b*VW+l of a row of len elements is padding when it is >= len
  function automatic logic [DW-1:0] pad_ref(input logic [DW-1:0] d, input int len, input int b);
    pad_ref = d;
    for (int l = 0; l < VW; l++) if (b * VW + l >= len) pad_ref[l*16 +: 16] = 16'hFF80;
  endfunction
  // Monitor: pops the scoreboard on every output handshake and checks stall stability and done timing
  always @(negedge clk) begin
    item_t e;
    if (rst_n) begin
      if (done_next) check("done_timing", flags.done, 1);
      done_next = 0;
      if (hold_chk) begin
        check("stall_valid", sout.valid, 1);
        check("stall_data", sout.data, hold_data);
      end
      hold_chk  = sout.valid && !sout.ready && !clear;
      hold_data = sout.data;
      if (flags.done) done_cnt++;
      if (sout.valid && sout.ready) begin
        check("beat_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("data", sout.data, e.data);
          check("strb", sout.strb, e.strb);
          check("row_last", flags.row_last, e.last);
          done_next = e.fin;
        end
      end
    end
  end
  task automatic run_job(input int len, input int rows, input int pct, input bit gapless);
    int    bpr   = (len + VW - 1) / VW;
    int    total = (len == 0 || rows == 0) ? 0 : bpr * rows;
    int    k = 0, t = 0, first = 0, last = 0, d0 = done_cnt;
    item_t e;
    ready_pct = pct;
    sin.valid = 1'b0;
    @(posedge clk); #1;
    ctrl = '{start: 1'b1, row_length: 32'(len), n_rows: 32'(rows)};
    @(posedge clk); #1;
    ctrl = '{start: 1'b1, row_length: $urandom, n_rows: $urandom};
    @(negedge clk);
    if (total == 0) check("done_after_start", flags.done, 1);
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    while (k < total && t < 4000) begin
      sin.valid = gapless || ($urandom_range(3) != 0);
      sin.data  = {7{$urandom}};
      sin.strb  = 28'($urandom);
      @(negedge clk);
      t++;
      if (sin.valid && sin.ready) begin
        e.data = pad_ref(sin.data, len, k % bpr);
        e.strb = sin.strb;
        e.last = (k % bpr) == bpr - 1;
        e.fin  = k == total - 1;
        sb.push_back(e);
        if (k == 0) first = t;
        last = t;
        k++;
      end
      @(posedge clk); #1;
    end
    check("in_beats", k, total);
    if (gapless && total > 0) check("gapless", last - first, total - 1);
    sin.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("extra_ready", sin.ready, 0);
      @(posedge clk); #1;
    end
    sin.valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("sb_empty", sb.size(), 0);
    check("busy_end", flags.busy, 0);
  endtask
  initial begin
    int d0;
    sin.valid = 1'b0;
    sin.data  = '0;
    sin.strb  = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", sout.valid, 0);
    check("rst_flags", flags, 0);
    check("rst_in_ready", sin.ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job(28, 2, 100, 1);
    run_job(17, 1, 100, 1);
    run_job(5, 3, 50, 0);
    run_job(0, 4, 100, 0);
    run_job(9, 0, 100, 0);
    ready_pct = 0;
    @(posedge clk); #1;
    ctrl = '{start: 1'b1, row_length: 32'd42, n_rows: 32'd1};
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    sin.valid  = 1'b1;
    sin.data   = {7{$urandom}};
    @(negedge clk);
    check("clr_in_ready", sin.ready, 1);
    @(posedge clk); #1;
    sin.data = {7{$urandom}};
    @(negedge clk);
    check("clr_slot_valid", sout.valid, 1);
    check("clr_in_stall", sin.ready, 0);
    d0 = done_cnt;
    @(posedge clk); #1;
    clear     = 1'b1;
    sin.valid = 1'b0;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_out_valid", sout.valid, 0);
    check("clr_busy", flags.busy, 0);
    repeat (4) @(negedge clk);
    check("clr_no_done", done_cnt - d0, 0);
    run_job(14, 1, 100, 1);
    run_job(70, 2, 100, 1);
    repeat (8) run_job($urandom_range(1, 60), $urandom_range(1, 4), $urandom_range(30, 100), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
